and_chain_seq: RTL and testbench
================================

# and_chain_seq

Bit-serial sequencer that evaluates the 9-stage AND2 reduction chain over an 8-bit operand vector, one AND2 stage per clock, through a single shared AND2 datapath slice. It sits between an upstream valid/ready producer and a downstream valid/ready consumer. It replaces the unrolled combinational chain where area matters more than latency, and it produces bit-exact results against that chain.

## Interface
Parameters:
- N_IN, 8, operand width; the chain has N_IN+1 stages.
- STW, $clog2(N_IN+1), width of the stage counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand vector offered.
- in_ready  output  1  block accepts an operand; high only in IDLE.
- in_data  input  N_IN  operand bits; bit k corresponds to chain input IN(k+1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  1  chain result (OUT).
- busy  output  1  high in RUN or DONE.
- stage  output  STW  current stage index; 0 outside RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into opnd, set acc=1 and stage=0, and go to RUN.
- RUN: each cycle computes acc <= acc & operand(stage), then stage increments.
- Operand selection, which gives the exact chain order:
  - stage 0 → opnd[1]
  - stage 1 → acc (identity step, op1&op1)
  - stage 2 → opnd[0]
  - stage s≥3 → opnd[s-1]
- When stage==N_IN is processed, go to DONE. Stage N_IN uses opnd[N_IN-1].
- DONE: out_valid=1 and out_data=acc. On out_ready, go to IDLE and clear out_valid. out_data holds stable while out_valid=1 and !out_ready.
- in_data is ignored outside the IDLE handshake; later changes to in_data do not affect a running evaluation.
- No accept in DONE, even if out_ready is high that same cycle. The next accept can happen at the earliest on the cycle after the return to IDLE.
- Reset, including assertion mid-RUN or mid-DONE:
  - FSM goes to IDLE; the in-flight operand is discarded and no out_valid is produced.
  - Output values under reset: in_ready=1, out_valid=0, out_data=0, busy=0, stage=0.

## Timing
- The accept handshake registers at edge T0. RUN occupies edges T1..T(N_IN+1); out_valid rises after edge T(N_IN+1).
- Latency from accept to out_valid is N_IN+1 cycles (9 at default), without the early-exit macro.
- Throughput is one result per N_IN+3 cycles with out_ready tied high (accept, N_IN+1 RUN cycles, DONE).
- Outputs are registered; there is no combinational path from in_valid or out_ready to any output.
- in_ready is a decode of the registered state.

## Configuration
- AND_SEQ_EARLY_EXIT_EN defined: in RUN, when the next acc value is 0, go to DONE on that edge. The result is identical and the latency is variable, with a minimum of 1 RUN cycle (opnd[1]=0).
- AND_SEQ_EARLY_EXIT_EN undefined: fixed N_IN+1 RUN cycles regardless of data.

## Structure
- Shared package and_seq_pkg holds:
  - the state enum typedef `and_seq_state_e` (IDLE, RUN, DONE);
  - default constant N_IN_DEF=8;
  - the stage-index encoding constants STG_SEED=0, STG_IDENT=1, STG_FIRST_LIN=2.
- One sub-module, and_seq_opsel: a combinational operand selector that takes (opnd, acc, stage) and returns the selected bit. The shared AND2 and the FSM stay in the top module.

## Test plan
- Reset values: assert rst_n=0 → in_ready=1, out_valid=0, out_data=0, busy=0, stage=0.
- All ones: in_data=8'hFF, out_ready=1 → out_valid 9 cycles after accept, out_data=1, stage steps 0..8 during RUN.
- Single zero at the last stage: in_data=8'h7F → out_data=0, 9-cycle latency. With AND_SEQ_EARLY_EXIT_EN the latency is still 9.
- Early exit: in_data=8'hFD (bit1=0) → out_data=0. Latency is 9 without the macro and 1 with it.
- Backpressure: in_data=8'hFF, out_ready=0 for 5 cycles → out_valid and out_data=1 held stable, in_ready=0; return to IDLE on the cycle after out_ready=1.
- Reset mid-RUN: accept 8'hFF, pull rst_n low at stage 4 → IDLE immediately with out_valid=0. After release, accepting 8'hFE yields out_data=0 with no stale result.

Source files
------------

// File: rtl/and_seq_pkg.sv
// rtl/and_seq_pkg.sv - shared types and constants for the AND2 chain sequencer
// Macro: AND_SEQ_EARLY_EXIT_EN (consumed by and_chain_seq)
package and_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } and_seq_state_e;

    localparam int N_IN_DEF = 8;

    // Stage-index encoding of the chain order
    localparam int STG_SEED      = 0;  // first stage ANDs opnd[1] into the seed
    localparam int STG_IDENT     = 1;  // identity step (op1 & op1)
    localparam int STG_FIRST_LIN = 2;  // opnd[0]; stages >= 3 then take opnd[s-1]

endpackage

// File: rtl/and_seq_if.sv
// rtl/and_seq_if.sv - producer/consumer handshake bundle of the AND2 chain sequencer
// Ports: in_valid/in_ready/in_data (operand side), out_valid/out_ready/out_data
// (result side), busy and stage (status). slave = sequencer, master = environment.
interface and_seq_if #(
    parameter int N_IN = 8,
    parameter int STW  = $clog2(N_IN + 1)
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_data;
    logic            busy;
    logic [STW-1:0]  stage;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, stage
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, stage
    );
endinterface

// File: rtl/and_seq_opsel.sv
// rtl/and_seq_opsel.sv - combinational operand selector for one AND2 chain stage
// Ports: opnd (latched operand), acc (running result), stage (index) -> sel (bit to AND)
module and_seq_opsel
    import and_seq_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int STW  = $clog2(N_IN + 1)
) (
    input  logic [N_IN-1:0] opnd,
    input  logic            acc,
    input  logic [STW-1:0]  stage,
    output logic            sel
);

    always_comb begin
        sel = 1'b0;
        if (stage == STW'(STG_SEED)) begin
            sel = opnd[1];
        end else if (stage == STW'(STG_IDENT)) begin
            // Selecting acc makes acc & acc, reproducing the chain's op1&op1 stage
            sel = acc;
        end else if (stage == STW'(STG_FIRST_LIN)) begin
            sel = opnd[0];
        end else begin
            for (int k = 2; k < N_IN; k++) begin
                if (stage == STW'(k + 1)) begin
                    sel = opnd[k];
                end
            end
        end
    end

endmodule

// File: rtl/and_chain_seq.sv
// rtl/and_chain_seq.sv - bit-serial sequencer for the N_IN+1 stage AND2 reduction chain
// Ports: clk, rst_n (async active-low), bus (and_seq_if.slave: in_valid/in_ready/in_data,
// out_valid/out_ready/out_data, busy, stage).
// Macro: AND_SEQ_EARLY_EXIT_EN - leave RUN as soon as the accumulator drops to 0.
module and_chain_seq
    import and_seq_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int STW  = $clog2(N_IN + 1)
) (
    input  logic   clk,
    input  logic   rst_n,
    and_seq_if.slave bus
);

    localparam logic [STW-1:0] STAGE_LAST = STW'(N_IN);

    and_seq_state_e  state_q, state_d;
    logic [N_IN-1:0] opnd_q, opnd_d;
    logic            acc_q, acc_d;
    logic [STW-1:0]  stage_q, stage_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_data_q, out_data_d;
    logic            busy_q, busy_d;

    logic sel_bit;
    logic and2_y;
    logic last_stage;

    and_seq_opsel #(
        .N_IN (N_IN),
        .STW  (STW)
    ) u_opsel (
        .opnd  (opnd_q),
        .acc   (acc_q),
        .stage (stage_q),
        .sel   (sel_bit)
    );

    // The single shared AND2 slice
    assign and2_y = acc_q & sel_bit;

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        stage_d    = stage_q;
        last_stage = (stage_q == STAGE_LAST);
`ifdef AND_SEQ_EARLY_EXIT_EN
        last_stage = last_stage || !and2_y;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    opnd_d  = bus.in_data;
                    acc_d   = 1'b1;
                    stage_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = and2_y;
                if (last_stage) begin
                    stage_d = '0;
                    state_d = DONE;
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            DONE: begin
                // No accept here: IDLE must be registered first
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                stage_d = '0;
            end
        endcase

        // Outputs are registered from the next state so they align with state_q
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
        out_data_d  = (state_d == DONE) ? acc_d : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opnd_q      <= '0;
            acc_q       <= 1'b0;
            stage_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            stage_q     <= stage_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.stage     = stage_q;

endmodule

// File: tb/tb_and_chain_seq.sv
// tb/tb_and_chain_seq.sv - self-checking bench for and_chain_seq
module tb_and_chain_seq;
    import and_seq_pkg::*;

    localparam int N_IN = N_IN_DEF;
    localparam int STW  = $clog2(N_IN + 1);

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   stage_log[$];

    and_seq_if #(.N_IN(N_IN), .STW(STW)) bus ();

    and_chain_seq #(.N_IN(N_IN), .STW(STW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the chain is IN2 & IN2 & IN1 & IN3 & ... & IN8 applied in order.
    // Result is the AND of all operand bits; early exit stops after the first 0 in that order.
    function automatic void model(input logic [7:0] d, output logic res, output int lat);
        int   order [9] = '{1, -1, 0, 2, 3, 4, 5, 6, 7};
        logic acc;
        logic b;
        acc = 1'b1;
        lat = N_IN + 1;
        for (int i = 0; i < 9; i++) begin
            b   = (order[i] < 0) ? acc : d[3'(order[i])];
            acc = acc & b;
`ifdef AND_SEQ_EARLY_EXIT_EN
            if (!acc && lat == N_IN + 1 && i < N_IN) lat = i + 1;
            if (!acc && lat == N_IN + 1) lat = i + 1;
`endif
        end
        res = acc;
    endfunction

    task automatic do_txn(input logic [7:0] d, input int hold, input string nm);
        logic exp_r;
        int   exp_lat;
        int   n;
        model(d, exp_r, exp_lat);
        stage_log.delete();
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL %s accept_timeout: in_ready=%0b expected 1", nm, bus.in_ready);
            return;
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            stage_log.push_back(int'(bus.stage));
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== exp_lat) begin
            errors++;
            $display("FAIL %s latency d=%h: got %0d expected %0d", nm, d, n, exp_lat);
        end
        checks++;
        if (bus.out_data !== exp_r) begin
            errors++;
            $display("FAIL %s out_data d=%h: got %0b expected %0b", nm, d, bus.out_data, exp_r);
        end
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp_r || bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s hold%0d: valid=%0b data=%0b in_ready=%0b expected 1 %0b 0",
                             nm, h, bus.out_valid, bus.out_data, bus.in_ready, exp_r);
                end
            end
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: valid=%0b in_ready=%0b busy=%0b expected 0 1 0",
                     nm, bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 1'b0 ||
            bus.busy !== 1'b0 || bus.stage !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%0b vld=%0b data=%0b busy=%0b stage=%0d expected 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.busy, bus.stage);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        do_txn(8'hFF, 0, "all_ones");
        checks++;
        if (stage_log.size() != N_IN + 1) begin
            errors++;
            $display("FAIL stage_walk_len: got %0d expected %0d", stage_log.size(), N_IN + 1);
        end else begin
            for (int i = 0; i <= N_IN; i++) begin
                checks++;
                if (stage_log[i] != i) begin
                    errors++;
                    $display("FAIL stage_walk[%0d]: got %0d expected %0d", i, stage_log[i], i);
                end
            end
        end
    endtask

    task automatic test_directed();
        do_txn(8'h7F, 0, "last_zero");
        do_txn(8'hFD, 0, "bit1_zero");
        do_txn(8'hFE, 0, "bit0_zero");
        do_txn(8'h00, 0, "all_zero");
    endtask

    task automatic test_backpressure();
        do_txn(8'hFF, 5, "backpressure");
    endtask

    task automatic test_reset_mid_run();
        int n;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hFF;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.stage != 4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.stage != 4) begin
            errors++;
            $display("FAIL mid_run_reach_stage4: got %0d expected 4", bus.stage);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.stage !== '0) begin
            errors++;
            $display("FAIL mid_run_reset: rdy=%0b vld=%0b busy=%0b stage=%0d expected 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.stage);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle%0d: vld=%0b busy=%0b expected 0 0", c, bus.out_valid, bus.busy);
            end
        end
        do_txn(8'hFE, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom);
            if (i % 3 == 0) d = 8'hFF;
            else if (i % 3 == 1) d = d | 8'($urandom) | 8'($urandom);
            do_txn(d, int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_back_to_back();
        int  rises[$];
        bit  prev;
        bit  bad_accept;
        int  n;
        prev          = 1'b0;
        bad_accept    = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_data   = 8'hFF;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (bus.out_valid && !prev) begin
                rises.push_back(c);
                checks++;
                if (bus.out_data !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_data: got %0b expected 1", bus.out_data);
                end
            end
            if (bus.out_valid && bus.in_ready) bad_accept = 1'b1;
            prev = bus.out_valid;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad_accept) begin
            errors++;
            $display("FAIL b2b_ready_in_done: got 1 expected 0");
        end
        checks++;
        if (rises.size() < 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected >=3", rises.size());
        end else begin
            for (int i = 1; i < rises.size(); i++) begin
                checks++;
                if (rises[i] - rises[i-1] != N_IN + 3) begin
                    errors++;
                    $display("FAIL b2b_period: got %0d expected %0d", rises[i] - rises[i-1], N_IN + 3);
                end
            end
        end
        n = 0;
        while ((bus.busy || bus.out_valid) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: busy=%0b expected 0", bus.busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_all_ones();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
